score_accumulator: RTL and testbench

Game-side scoring stage that sits directly upstream of the 8-digit seven-segment display controller. It accepts graded hit events, tracks combo and multiplier, and accumulates a saturating score. It drives the display's 32-bit binary score input with a rate-limited count-up value, and it keeps a session high score.

---
 rtl/score_accumulator_if.sv | 32 +++
 rtl/score_accumulator.sv | 138 +++++++++++++
 tb/tb_score_accumulator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_accumulator_if.sv
// Hit/round control inputs and score outputs of the score accumulator.
// master: game logic side; slave: score_accumulator.
interface score_accumulator_if;
  logic        GAME_START;
  logic        GAME_END;
  logic        HIT_VALID;
  logic [1:0]  HIT_GRADE;
  logic [31:0] BINARY_SCORE;
  logic [31:0] SCORE_TOTAL;
  logic [31:0] HIGH_SCORE;
  logic [9:0]  COMBO;
  logic [2:0]  MULT;
  logic        NEW_HIGH;
  logic        BUSY;
  logic [1:0]  STATE;

  modport master (
    output GAME_START, GAME_END,
    output HIT_VALID, HIT_GRADE,
    input  BINARY_SCORE, SCORE_TOTAL,
    input  HIGH_SCORE, COMBO, MULT,
    input  NEW_HIGH, BUSY, STATE
  );

  modport slave (
    input  GAME_START, GAME_END,
    input  HIT_VALID, HIT_GRADE,
    output BINARY_SCORE, SCORE_TOTAL,
    output HIGH_SCORE, COMBO, MULT,
    output NEW_HIGH, BUSY, STATE
  );
endinterface

// File: rtl/score_accumulator.sv
// Combo/multiplier scoring with saturating total, ramped display value
// and session high score. Ports: CLK, RST (sync, active-low), bus.
module score_accumulator #(
  parameter int unsigned PTS_GOOD    = 100,
  parameter int unsigned PTS_GREAT   = 200,
  parameter int unsigned PTS_PERFECT = 300,
  parameter int unsigned COMBO_STEP  = 10,
  parameter int unsigned MAX_MULT    = 4,
  parameter int unsigned SCORE_MAX   = 99999999,
  parameter int unsigned COMBO_MAX   = 999,
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned RAMP_STEP   = 50
) (
  input logic CLK,
  input logic RST,
  score_accumulator_if.slave bus
);

  localparam int PW =
    (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    TALLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [31:0]   score_q;
  logic [31:0]   bin_q;
  logic [31:0]   high_q;
  logic [9:0]    combo_q;
  logic          new_high_q;
  logic [PW-1:0] presc_q;

  logic [31:0] mult_raw;
  logic [2:0]  mult;
  logic [31:0] base;
  logic [31:0] add;
  logic [32:0] sum;
  logic [31:0] sat;
  logic [9:0]  combo_inc;
  logic        tick;
  logic [31:0] diff;
  logic [31:0] inc;

  always_comb begin
    mult_raw = 32'(combo_q) / COMBO_STEP + 32'd1;
    mult = (mult_raw > MAX_MULT) ?
      3'(MAX_MULT) : mult_raw[2:0];
  end

  always_comb begin
    base = 32'd0;
    unique case (bus.HIT_GRADE)
      2'd1:    base = PTS_GOOD;
      2'd2:    base = PTS_GREAT;
      2'd3:    base = PTS_PERFECT;
      default: base = 32'd0;
    endcase
  end

  // 33-bit sum so a large add can never wrap past the ceiling
  always_comb begin
    add = base * {29'd0, mult};
    sum = {1'b0, score_q} + {1'b0, add};
    sat = (sum > 33'(SCORE_MAX)) ?
      SCORE_MAX : sum[31:0];
    combo_inc = (32'(combo_q) >= COMBO_MAX) ?
      combo_q : combo_q + 10'd1;
  end

  always_comb begin
    tick = (presc_q == PW'(RAMP_DIV - 1));
    diff = score_q - bin_q;
    inc  = (diff > RAMP_STEP) ? RAMP_STEP : diff;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      score_q    <= '0;
      bin_q      <= '0;
      high_q     <= '0;
      combo_q    <= '0;
      new_high_q <= 1'b0;
      presc_q    <= '0;
    end else if (bus.GAME_START) begin
      state_q    <= PLAY;
      score_q    <= '0;
      bin_q      <= '0;
      combo_q    <= '0;
      new_high_q <= 1'b0;
      presc_q    <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      // display only ever chases the total from below
      if (tick && (bin_q < score_q))
        bin_q <= bin_q + inc;
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (bus.HIT_VALID) begin
            if (bus.HIT_GRADE == 2'd0) begin
              combo_q <= '0;
            end else begin
              score_q <= sat;
              combo_q <= combo_inc;
            end
          end
          if (bus.GAME_END)
            state_q <= TALLY;
        end
        TALLY: begin
          if (bin_q == score_q) begin
            new_high_q <= (score_q > high_q);
            if (score_q > high_q)
              high_q <= score_q;
            state_q <= DONE;
          end
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BINARY_SCORE = bin_q;
  assign bus.SCORE_TOTAL  = score_q;
  assign bus.HIGH_SCORE   = high_q;
  assign bus.COMBO        = combo_q;
  assign bus.MULT         = mult;
  assign bus.NEW_HIGH     = new_high_q;
  assign bus.BUSY         = (bin_q != score_q);
  assign bus.STATE        = state_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: main instance with a fast
// ramp, plus a low-ceiling instance for saturation.
module tb_score_accumulator;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 CLK = ~CLK;

  score_accumulator_if m_if ();
  score_accumulator_if s_if ();

  score_accumulator #(
    .RAMP_DIV (4),
    .RAMP_STEP(50)
  ) u_main (
    .CLK(CLK),
    .RST(RST),
    .bus(m_if.slave)
  );

  score_accumulator #(
    .SCORE_MAX(1000),
    .RAMP_DIV (4),
    .RAMP_STEP(50)
  ) u_sat (
    .CLK(CLK),
    .RST(RST),
    .bus(s_if.slave)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_m();
    m_if.GAME_START = 1'b1;
    step();
    m_if.GAME_START = 1'b0;
  endtask

  task automatic hit_m(logic [1:0] g, int gap = 0);
    m_if.HIT_VALID = 1'b1;
    m_if.HIT_GRADE = g;
    step();
    m_if.HIT_VALID = 1'b0;
    m_if.HIT_GRADE = 2'd0;
    if (gap > 0) step(gap);
  endtask

  task automatic end_m();
    m_if.GAME_END = 1'b1;
    step();
    m_if.GAME_END = 1'b0;
  endtask

  task automatic hit_s(logic [1:0] g);
    s_if.HIT_VALID = 1'b1;
    s_if.HIT_GRADE = g;
    step();
    s_if.HIT_VALID = 1'b0;
    s_if.HIT_GRADE = 2'd0;
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while (m_if.STATE != 2'd3 && n < 2000) begin
      step();
      n++;
    end
    chk(tag, 32'(m_if.STATE), 32'd3);
  endtask

  task automatic eleven_perfect();
    for (int i = 0; i < 11; i++) hit_m(2'd3, 2);
  endtask

  initial begin
    m_if.GAME_START = 1'b0;
    m_if.GAME_END   = 1'b0;
    m_if.HIT_VALID  = 1'b0;
    m_if.HIT_GRADE  = 2'd0;
    s_if.GAME_START = 1'b0;
    s_if.GAME_END   = 1'b0;
    s_if.HIT_VALID  = 1'b0;
    s_if.HIT_GRADE  = 2'd0;
    step(2);

    chk("rst_score", m_if.SCORE_TOTAL, 0);
    chk("rst_bin", m_if.BINARY_SCORE, 0);
    chk("rst_mult", 32'(m_if.MULT), 1);
    chk("rst_state", 32'(m_if.STATE), 0);
    chk("rst_busy", 32'(m_if.BUSY), 0);
    RST = 1'b1;
    step();

    // ramp and tally: 300 points, 50 per 4-cycle tick
    start_m();
    chk("start_state", 32'(m_if.STATE), 1);
    hit_m(2'd3);
    chk("ramp_score", m_if.SCORE_TOTAL, 300);
    end_m();
    chk("tally_state", 32'(m_if.STATE), 2);
    chk("tally_busy", 32'(m_if.BUSY), 1);
    for (int k = 1; k <= 6; k++) begin
      logic [31:0] prev;
      int n;
      prev = m_if.BINARY_SCORE;
      n = 0;
      do begin
        step();
        n++;
      end while (m_if.BINARY_SCORE == prev && n < 10);
      chk($sformatf("ramp_val%0d", k),
          m_if.BINARY_SCORE, 32'(50 * k));
      if (k > 1)
        chk($sformatf("ramp_gap%0d", k), 32'(n), 4);
    end
    chk("ramp_busy_low", 32'(m_if.BUSY), 0);
    chk("ramp_still_tally", 32'(m_if.STATE), 2);
    step();
    chk("ramp_done", 32'(m_if.STATE), 3);
    chk("ramp_high", m_if.HIGH_SCORE, 300);
    chk("ramp_newhigh", 32'(m_if.NEW_HIGH), 1);

    // combo multiplier then miss handling
    start_m();
    for (int i = 0; i < 10; i++) hit_m(2'd3, 2);
    chk("c10_score", m_if.SCORE_TOTAL, 3000);
    chk("c10_combo", 32'(m_if.COMBO), 10);
    chk("c10_mult", 32'(m_if.MULT), 2);
    hit_m(2'd3, 2);
    chk("c11_score", m_if.SCORE_TOTAL, 3600);
    chk("c11_combo", 32'(m_if.COMBO), 11);
    hit_m(2'd0, 2);
    chk("miss_combo", 32'(m_if.COMBO), 0);
    chk("miss_score", m_if.SCORE_TOTAL, 3600);
    chk("miss_mult", 32'(m_if.MULT), 1);
    hit_m(2'd1, 2);
    chk("good_combo", 32'(m_if.COMBO), 1);
    chk("good_score", m_if.SCORE_TOTAL, 3700);
    end_m();
    wait_done("r1_done");
    chk("r1_bin", m_if.BINARY_SCORE, 3700);
    chk("r1_high", m_if.HIGH_SCORE, 3700);
    chk("r1_newhigh", 32'(m_if.NEW_HIGH), 1);

    // lower round keeps the high score
    start_m();
    chk("r2_newhigh_clr", 32'(m_if.NEW_HIGH), 0);
    repeat (4) hit_m(2'd3, 1);
    chk("r2_score", m_if.SCORE_TOTAL, 1200);
    end_m();
    wait_done("r2_done");
    chk("r2_high", m_if.HIGH_SCORE, 3700);
    chk("r2_newhigh", 32'(m_if.NEW_HIGH), 0);

    // tie round; last hit lands with GAME_END
    start_m();
    eleven_perfect();
    hit_m(2'd0, 1);
    m_if.GAME_END = 1'b1;
    hit_m(2'd1);
    m_if.GAME_END = 1'b0;
    chk("tie_end_state", 32'(m_if.STATE), 2);
    chk("tie_end_score", m_if.SCORE_TOTAL, 3700);
    wait_done("tie_done");
    chk("tie_high", m_if.HIGH_SCORE, 3700);
    chk("tie_newhigh", 32'(m_if.NEW_HIGH), 0);

    // hit in DONE is ignored
    hit_m(2'd3, 1);
    chk("done_hit_score", m_if.SCORE_TOTAL, 3700);
    chk("done_hit_combo", 32'(m_if.COMBO), 1);

    // start wins over same-cycle hit and end
    m_if.GAME_END = 1'b1;
    m_if.GAME_START = 1'b1;
    hit_m(2'd3);
    m_if.GAME_START = 1'b0;
    m_if.GAME_END = 1'b0;
    chk("prio_score", m_if.SCORE_TOTAL, 0);
    chk("prio_combo", 32'(m_if.COMBO), 0);
    chk("prio_state", 32'(m_if.STATE), 1);
    chk("prio_bin", m_if.BINARY_SCORE, 0);
    chk("prio_high", m_if.HIGH_SCORE, 3700);

    // reset mid-round
    hit_m(2'd3, 1);
    hit_m(2'd2);
    chk("pre_rst_score", m_if.SCORE_TOTAL, 500);
    RST = 1'b0;
    step();
    chk("mrst_score", m_if.SCORE_TOTAL, 0);
    chk("mrst_bin", m_if.BINARY_SCORE, 0);
    chk("mrst_high", m_if.HIGH_SCORE, 0);
    chk("mrst_combo", 32'(m_if.COMBO), 0);
    chk("mrst_mult", 32'(m_if.MULT), 1);
    chk("mrst_state", 32'(m_if.STATE), 0);
    RST = 1'b1;
    step();
    hit_m(2'd3, 1);
    chk("idle_hit_score", m_if.SCORE_TOTAL, 0);
    chk("idle_hit_state", 32'(m_if.STATE), 0);

    // saturation at 1000
    s_if.GAME_START = 1'b1;
    step();
    s_if.GAME_START = 1'b0;
    hit_s(2'd3);
    chk("sat1", s_if.SCORE_TOTAL, 300);
    hit_s(2'd3);
    chk("sat2", s_if.SCORE_TOTAL, 600);
    hit_s(2'd3);
    chk("sat3", s_if.SCORE_TOTAL, 900);
    hit_s(2'd3);
    chk("sat4", s_if.SCORE_TOTAL, 1000);
    hit_s(2'd3);
    chk("sat5", s_if.SCORE_TOTAL, 1000);
    chk("sat_combo", 32'(s_if.COMBO), 5);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
